// File: rtl/adc_arb_pkg.sv
// Shared types and constants for the ADC conversion arbiter: FSM states,
// SFR write-strobe indices on the DAC mux and DACTL bit positions.
package adc_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WEN0,
        ST_WSR0,
        ST_WEN1,
        ST_WSR1,
        ST_START,
        ST_WBSY,
        ST_WDON,
        ST_RPT,
        ST_ABORT
    } state_t;

    localparam int unsigned N_SFR      = 9;
    localparam int unsigned SFR_CTL    = 0;
    localparam int unsigned SFR_DACEN  = 1;
    localparam int unsigned SFR_SAREN  = 2;
    localparam int unsigned SFR_DACEN1 = 7;
    localparam int unsigned SFR_SAREN1 = 8;

    localparam int unsigned DACTL_START   = 0;
    localparam int unsigned DACTL_DACT_LO = 2;
    localparam int unsigned DACTL_DACYC   = 7;

    // Cycles the mux gets to acknowledge a start before the request is dropped.
    localparam int unsigned WBSY_LIMIT = 4;

endpackage

// File: rtl/adc_arb_rr.sv
// Round-robin requester picker: first active request at or after i_ptr,
// returned both one-hot and as an index.
module adc_arb_rr #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_vld
);

    localparam int unsigned IW = $clog2(N_REQ);

    int unsigned w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = (32'(i_ptr) + k) % N_REQ;
            if (!o_vld && i_req[IW'(w_j)]) begin
                o_vld            = 1'b1;
                o_idx            = IW'(w_j);
                o_gnt[IW'(w_j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_arb.sv
// ADC conversion arbiter: grants one requester at a time and drives the DAC mux
// SFR sequence. Optional WDON busy-timeout is compiled in with ADCARB_TIMEOUT_EN.
module adc_arb
    import adc_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned N_DACV  = 16,
    parameter int unsigned BIT_PTR = 4,
    parameter int unsigned T_TO    = 1023
) (
    input  logic                       clk,
    input  logic                       srstz,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*BIT_PTR-1:0]   req_ch,
    input  logic                       fw_own,
    input  logic                       cfg_dacyc,
    input  logic [1:0]                 cfg_dac_t,
    input  logic                       mux_busy,
    input  logic [8*N_DACV-1:0]        dacv_i,
    output logic [N_SFR-1:0]           o_wr,
    output logic [7:0]                 o_wdat,
    output logic [N_REQ-1:0]           done,
    output logic [7:0]                 rslt,
    output logic                       err,
    output logic                       arb_busy
);

    localparam int unsigned GW = $clog2(N_REQ);

    state_t               r_state, w_nxt;
    logic [GW-1:0]        r_ptr, r_gid, w_idx;
    logic [BIT_PTR-1:0]   r_ch, w_ch;
    logic [7:0]           r_rslt, w_rslt;
    logic [1:0]           r_wcnt;
    logic [N_REQ-1:0]     w_gnt;
    logic                 w_vld, w_grant, w_badch;
    logic [7:0]           w_lo, w_hi, w_dacv;

`ifdef ADCARB_TIMEOUT_EN
    logic [9:0]           r_tcnt;
`else
    // T_TO only takes effect when the WDON timeout is compiled in.
    if (T_TO == 0) begin : g_no_timeout
    end
`endif

    adc_arb_rr #(.N_REQ(N_REQ)) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    always_comb begin
        w_ch = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) w_ch = req_ch[k*BIT_PTR +: BIT_PTR];
        end
    end

    assign w_badch  = 32'(r_ch) >= N_DACV;
    assign w_lo     = (32'(r_ch) < 32'd8)  ? (8'h01 << r_ch) : 8'h00;
    assign w_hi     = (32'(r_ch) >= 32'd8) ? (8'h01 << (r_ch - BIT_PTR'(8))) : 8'h00;
    assign w_dacv   = dacv_i[{r_ch, 3'b000} +: 8];
    assign arb_busy = (r_state != ST_IDLE);
    assign rslt     = w_rslt;

    always_ff @(posedge clk) begin
        if (!srstz) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_ch    <= '0;
            r_rslt  <= '0;
            r_wcnt  <= '0;
`ifdef ADCARB_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
        end else begin
            r_state <= w_nxt;
            r_rslt  <= w_rslt;
            r_wcnt  <= (r_state == ST_WBSY) ? r_wcnt + 2'd1 : '0;
`ifdef ADCARB_TIMEOUT_EN
            r_tcnt  <= (r_state == ST_WDON) ? r_tcnt + 10'd1 : '0;
`endif
            if (w_grant) begin
                r_gid <= w_idx;
                r_ch  <= w_ch;
                r_ptr <= (w_idx == GW'(N_REQ - 1)) ? '0 : w_idx + GW'(1);
            end
        end
    end

    always_comb begin
        w_nxt   = r_state;
        w_grant = 1'b0;
        w_rslt  = r_rslt;
        o_wr    = '0;
        o_wdat  = '0;
        done    = '0;
        err     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!fw_own && !mux_busy && w_vld) begin
                    w_grant = 1'b1;
                    w_nxt   = (32'(w_ch) >= N_DACV) ? ST_ABORT : ST_WEN0;
                end
            end
            ST_WEN0: begin
                o_wr[SFR_DACEN] = 1'b1;
                o_wdat          = w_lo;
                w_nxt           = ST_WSR0;
            end
            ST_WSR0: begin
                o_wr[SFR_SAREN] = 1'b1;
                o_wdat          = w_lo;
                w_nxt           = ST_WEN1;
            end
            ST_WEN1: begin
                o_wr[SFR_DACEN1] = 1'b1;
                o_wdat           = w_hi;
                w_nxt            = ST_WSR1;
            end
            ST_WSR1: begin
                o_wr[SFR_SAREN1] = 1'b1;
                o_wdat           = w_hi;
                w_nxt            = ST_START;
            end
            ST_START: begin
                o_wr[SFR_CTL]                  = 1'b1;
                o_wdat[DACTL_DACYC]            = cfg_dacyc;
                o_wdat[DACTL_DACT_LO +: 2]     = cfg_dac_t;
                o_wdat[DACTL_START]            = 1'b1;
                w_nxt                          = ST_WBSY;
            end
            ST_WBSY: begin
                if (mux_busy)
                    w_nxt = ST_WDON;
                else if (r_wcnt == 2'(WBSY_LIMIT - 1))
                    w_nxt = ST_ABORT;
            end
            ST_WDON: begin
                if (!mux_busy)
                    w_nxt = ST_RPT;
`ifdef ADCARB_TIMEOUT_EN
                else if (r_tcnt == 10'(T_TO - 1))
                    w_nxt = ST_ABORT;
`endif
            end
            ST_RPT: begin
                done[r_gid] = 1'b1;
                w_rslt      = w_dacv;
                w_nxt       = ST_IDLE;
            end
            ST_ABORT: begin
                // An out-of-range channel never started the mux, so no stop write.
                o_wr[SFR_CTL] = !w_badch;
                done[r_gid]   = 1'b1;
                w_rslt        = 8'h00;
                err           = 1'b1;
                w_nxt         = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

endmodule
